// File: rtl/ber_frame_reporter.sv
// ber_frame_reporter: counts checked bits and errored bits over a measurement
// window, latches the totals and sends them as an 8N1 UART result frame:
//   A5, bit_total[31:24..7:0], err_total[23:16..7:0]
// Optional feature macro: BER_CHECKSUM_EN appends a ninth byte holding the XOR
// of the eight preceding frame bytes.
module ber_frame_reporter #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned WINDOW_BITS  = 32'd1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        beat_valid,
    input  logic [3:0]  error_bits,
    input  logic [3:0]  bits_checked,
    output logic        uart_tx,
    output logic        busy,
    output logic        done,
    output logic [23:0] err_total,
    output logic [31:0] bit_total,
    output logic        err_sat
);

`ifdef BER_CHECKSUM_EN
    localparam int unsigned NUM_BYTES = 9;
`else
    localparam int unsigned NUM_BYTES = 8;
`endif
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {IDLE, MEASURE, LATCH, SEND} state_t;

    state_t            state, state_next;
    logic [31:0]       bit_acc;
    logic [23:0]       err_acc;
    logic              sat_flag;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_idx;
    logic [3:0]        byte_idx;
    logic [32:0]       bit_sum;
    logic [24:0]       err_sum;
    logic              beat_take;
    logic              bit_end;
    logic              frame_end;
    logic [7:0]        cur_byte;
`ifdef BER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    // Next-state decode, accumulator sums and UART timing strobes
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        beat_take  = (state == MEASURE) && beat_valid;
        bit_sum    = {1'b0, bit_acc} + 33'(bits_checked);
        err_sum    = {1'b0, err_acc} + 25'(error_bits);
        bit_end    = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
        frame_end  = bit_end && (bit_idx == 4'd9) && (byte_idx == 4'(NUM_BYTES - 1));
        case (state)
            IDLE:    if (start) state_next = MEASURE;
            MEASURE: begin
                if (abort)
                    state_next = IDLE;
                else if (beat_valid && (bit_sum >= 33'(WINDOW_BITS)))
                    state_next = LATCH;
            end
            LATCH:   state_next = SEND;
            SEND:    if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame byte selection from the latched totals
    always_comb begin
`ifdef BER_CHECKSUM_EN
        checksum = 8'hA5 ^ bit_total[31:24] ^ bit_total[23:16] ^ bit_total[15:8]
                 ^ bit_total[7:0] ^ err_total[23:16] ^ err_total[15:8] ^ err_total[7:0];
`endif
        case (byte_idx)
            4'd0:    cur_byte = 8'hA5;
            4'd1:    cur_byte = bit_total[31:24];
            4'd2:    cur_byte = bit_total[23:16];
            4'd3:    cur_byte = bit_total[15:8];
            4'd4:    cur_byte = bit_total[7:0];
            4'd5:    cur_byte = err_total[23:16];
            4'd6:    cur_byte = err_total[15:8];
            4'd7:    cur_byte = err_total[7:0];
`ifdef BER_CHECKSUM_EN
            4'd8:    cur_byte = checksum;
`endif
            default: cur_byte = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Window accumulators: cleared on start, saturating error count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_acc  <= '0;
            err_acc  <= '0;
            sat_flag <= 1'b0;
        end else if ((state == IDLE) && start) begin
            bit_acc  <= '0;
            err_acc  <= '0;
            sat_flag <= 1'b0;
        end else if (beat_take) begin
            bit_acc <= bit_sum[31:0];
            if (err_sum[24]) begin
                err_acc  <= '1;
                sat_flag <= 1'b1;
            end else begin
                err_acc <= err_sum[23:0];
            end
        end
    end

    // Result registers, updated only when a window completes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_total <= '0;
            err_total <= '0;
            err_sat   <= 1'b0;
        end else if (state == LATCH) begin
            bit_total <= bit_acc;
            err_total <= err_acc;
            err_sat   <= sat_flag;
        end
    end

    // UART transmitter: start bit is driven as LATCH hands over to SEND, so
    // each later bit is chosen from the byte already latched in the totals
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LATCH: begin
                    uart_tx  <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            if (frame_end) begin
                                uart_tx <= 1'b1;
                                done    <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 4'd1;
                                bit_idx  <= '0;
                                uart_tx  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            uart_tx <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    uart_tx  <= 1'b1;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ber_frame_reporter.sv
// Testbench for ber_frame_reporter: stimulus pushes expected frame bytes and
// totals into queues; a UART receiver/monitor pops and compares them.
module tb_ber_frame_reporter;

    localparam int CLKS = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        beat_valid = 1'b0;
    logic [3:0]  error_bits = '0;
    logic [3:0]  bits_checked = '0;
    logic        uart_tx;
    logic        busy;
    logic        done;
    logic [23:0] err_total;
    logic [31:0] bit_total;
    logic        err_sat;

    ber_frame_reporter #(
        .CLKS_PER_BIT(CLKS),
        .WINDOW_BITS (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .beat_valid  (beat_valid),
        .error_bits  (error_bits),
        .bits_checked(bits_checked),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .done        (done),
        .err_total   (err_total),
        .bit_total   (bit_total),
        .err_sat     (err_sat)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] bits;
        logic [23:0] errs;
        logic        sat;
    } totals_t;

    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    int          bytes_seen = 0;
    logic [7:0]  exp_bytes[$];
    totals_t     exp_totals[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART receiver and done monitor, sampling on the falling edge
    int         rx_cnt = 0;
    logic       rx_busy = 1'b0;
    logic [7:0] rx_byte = '0;
    always @(negedge clock) begin
        if (!reset) begin
            rx_busy = 1'b0;
        end else begin
            if (!rx_busy) begin
                if (uart_tx == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                if ((rx_cnt % CLKS == 0) && (rx_cnt <= 8 * CLKS))
                    rx_byte[rx_cnt / CLKS - 1] = uart_tx;
                if (rx_cnt == 9 * CLKS) begin
                    check("stop_bit", 64'(uart_tx), 64'd1);
                    bytes_seen++;
                    rx_busy = 1'b0;
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", rx_byte);
                    end else begin
                        check("frame_byte", 64'(rx_byte), 64'(exp_bytes.pop_front()));
                    end
                end
            end
            if (done) begin
                done_seen++;
                if (exp_totals.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    totals_t t;
                    t = exp_totals.pop_front();
                    check("bit_total", 64'(bit_total), 64'(t.bits));
                    check("err_total", 64'(err_total), 64'(t.errs));
                    check("err_sat",   64'(err_sat),   64'(t.sat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] b, input logic [23:0] e, input logic s);
        logic [7:0] fr[8];
        logic [7:0] x;
        totals_t    t;
        fr = '{8'hA5, b[31:24], b[23:16], b[15:8], b[7:0], e[23:16], e[15:8], e[7:0]};
        x  = '0;
        for (int i = 0; i < 8; i++) begin
            exp_bytes.push_back(fr[i]);
            x = x ^ fr[i];
        end
`ifdef BER_CHECKSUM_EN
        exp_bytes.push_back(x);
`endif
        t.bits = b;
        t.errs = e;
        t.sat  = s;
        exp_totals.push_back(t);
    endtask

    task automatic beat(input logic [3:0] b, input logic [3:0] e);
        beat_valid   = 1'b1;
        bits_checked = b;
        error_bits   = e;
        tick();
        beat_valid   = 1'b0;
        error_bits   = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while ((done_seen < target) && (n < 1000)) begin
            tick();
            n++;
        end
        check("done_timeout", 64'(done_seen >= target), 64'd1);
    endtask

    initial begin
        logic tx_low;
        int   base;
        int   n;

        // Reset values
        repeat (3) tick();
        check("rst_uart_tx",   64'(uart_tx),   64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_err_total", 64'(err_total), 64'd0);
        check("rst_bit_total", 64'(bit_total), 64'd0);
        check("rst_err_sat",   64'(err_sat),   64'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_after_rst", 64'(busy), 64'd0);

        // Reference window: start+abort+beat together, errors on beats 2,5,7
        push_frame(32'd64, 24'd3, 1'b0);
        start = 1'b1; abort = 1'b1; beat_valid = 1'b1; bits_checked = 4'd8; error_bits = 4'd1;
        tick();
        start = 1'b0; abort = 1'b0; beat_valid = 1'b0; error_bits = '0;
        check("start_wins", 64'(busy), 64'd1);
        for (int unsigned i = 1; i <= 8; i++)
            beat(4'd8, (i == 2 || i == 5 || i == 7) ? 4'd1 : 4'd0);
        wait_done(1);

        // Overshoot with 13-bit beats; beat in LATCH, start/abort in SEND ignored
        push_frame(32'd65, 24'd0, 1'b0);
        pulse_start();
        for (int unsigned i = 0; i < 5; i++) beat(4'd13, 4'd0);
        beat(4'd13, 4'd7);
        repeat (20) tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("busy_mid_send",      64'(busy),      64'd1);
        check("bit_total_mid_send", 64'(bit_total), 64'd65);
        wait_done(2);

        // Abort after three beats
        pulse_start();
        for (int unsigned i = 0; i < 3; i++) beat(4'd8, 4'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle",      64'(busy),      64'd0);
        check("abort_bit_total", 64'(bit_total), 64'd65);
        check("abort_err_total", 64'(err_total), 64'd0);
        tx_low = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            tick();
            if (uart_tx !== 1'b1) tx_low = 1'b1;
        end
        check("abort_tx_idle", 64'(tx_low), 64'd0);

        // Saturation: accumulator preloaded near full scale
        push_frame(32'd64, 24'hFFFFFF, 1'b1);
        pulse_start();
        for (int unsigned i = 0; i < 3; i++) beat(4'd8, 4'd0);
        force dut.err_acc = 24'hFFFFFE;
        tick();
        release dut.err_acc;
        beat(4'd8, 4'd5);
        for (int unsigned i = 0; i < 4; i++) beat(4'd8, 4'd0);
        wait_done(3);

        // Reset during the third frame byte
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h00);
        base = bytes_seen;
        pulse_start();
        for (int unsigned i = 0; i < 8; i++) beat(4'd8, 4'd0);
        n = 0;
        while ((bytes_seen < base + 2) && (n < 1000)) begin
            tick();
            n++;
        end
        check("two_bytes_before_reset", 64'(bytes_seen >= base + 2), 64'd1);
        repeat (8) tick();
        reset = 1'b0;
        #1;
        check("rst_mid_uart_tx",   64'(uart_tx),   64'd1);
        check("rst_mid_busy",      64'(busy),      64'd0);
        check("rst_mid_done",      64'(done),      64'd0);
        check("rst_mid_err_total", 64'(err_total), 64'd0);
        check("rst_mid_bit_total", 64'(bit_total), 64'd0);
        check("rst_mid_err_sat",   64'(err_sat),   64'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (50) tick();
        check("idle_after_mid_rst", 64'(busy),    64'd0);
        check("tx_after_mid_rst",   64'(uart_tx), 64'd1);

        check("done_count",       64'(done_seen),         64'd3);
        check("bytes_left",       64'(exp_bytes.size()),  64'd0);
        check("totals_left",      64'(exp_totals.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ber_frame_reporter.md
BER_FRAME_REPORTER -- requirements
Module: ber_frame_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104: UART bit period in clock cycles (12 MHz / 115200).
REQ-002 Parameter WINDOW_BITS, default 1048576: checked bits per measurement window, 32-bit value, minimum 1.
REQ-003 Port clock input 1: single clock; all state on rising edge.
REQ-004 Port reset input 1: asynchronous, active-low reset.
REQ-005 Port start input 1: one-cycle pulse that opens a measurement window.
REQ-006 Port abort input 1: terminates an open window without reporting.
REQ-007 Port beat_valid input 1: error_bits/bits_checked valid this cycle.
REQ-008 Port error_bits input 4: errored bits in this beat, range 0..13.
REQ-009 Port bits_checked input 4: bits compared in this beat, 8 (PRBS-7) or 13 (PRBS-13).
REQ-010 Port uart_tx output 1: 8N1 serial result frame, idle high.
REQ-011 Port busy output 1: high in MEASURE, LATCH or SEND.
REQ-012 Port done output 1: one-cycle pulse after the last frame stop bit.
REQ-013 Port err_total output 24: latched error count of the last completed window.
REQ-014 Port bit_total output 32: latched bit count of the last completed window.
REQ-015 Port err_sat output 1: latched; error accumulator saturated in the last completed window.

Function
REQ-016 FSM states SHALL be IDLE, MEASURE, LATCH, SEND.
REQ-017 IDLE->MEASURE on start; both accumulators and the saturation flag clear in the same edge.
REQ-018 In MEASURE each beat_valid cycle SHALL add bits_checked to the 32-bit bit accumulator and error_bits to the 24-bit error accumulator.
REQ-019 Error accumulator SHALL saturate at 0xFFFFFF and set the internal saturation flag; no wrap-around.
REQ-020 MEASURE->LATCH the cycle after the bit accumulator reaches or exceeds WINDOW_BITS; the overshooting beat SHALL be counted in full.
REQ-021 Beats arriving in LATCH or SEND SHALL be ignored.
REQ-022 LATCH, one cycle: copy accumulators to bit_total/err_total, saturation flag to err_sat, then build the frame.
REQ-023 Frame byte order: 0xA5, bit_total[31:24], [23:16], [15:8], [7:0], err_total[23:16], [15:8], [7:0].
REQ-024 Each byte: start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; no idle gap between bytes.
REQ-025 SEND->IDLE after the last stop bit; done pulses high for exactly that one cycle.
REQ-026 abort in MEASURE SHALL return to IDLE next cycle; outputs keep their previous latched values; no frame is sent.
REQ-027 abort in IDLE, LATCH or SEND SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-028 start and abort in the same IDLE cycle: start wins.
REQ-029 beat_valid in the same cycle as start SHALL NOT be counted.

Reset
REQ-030 On reset low, asynchronously: state IDLE, uart_tx 1, busy 0, done 0, err_total 0, bit_total 0, err_sat 0, accumulators 0, baud counter 0.
REQ-031 Reset mid-SEND SHALL drive uart_tx high immediately and abandon the frame.
REQ-032 First transition out of IDLE only on the first start after reset deasserts.

Configuration
REQ-033 Macro BER_CHECKSUM_EN defined: a ninth byte, the XOR of the eight preceding bytes, is appended to the frame before done.
REQ-034 Macro BER_CHECKSUM_EN undefined: frame is exactly eight bytes; no checksum logic is instantiated.

Verification
REQ-035 WINDOW_BITS=64, CLKS_PER_BIT=4, start, 8 beats of bits_checked=8 with error_bits=1 on beats 2,5,7 -> bit_total=64, err_total=3, bytes A5 00 00 00 40 00 00 03 (+E6 with BER_CHECKSUM_EN), done once.
REQ-036 WINDOW_BITS=20, 2 beats bits_checked=13, error_bits=0 -> bit_total=26, err_total=0, err_sat=0.
REQ-037 Error accumulator preloaded to 0xFFFFFE by forcing, beat error_bits=5 -> err_total=0xFFFFFF, err_sat=1.
REQ-038 abort after 3 beats of an open window -> IDLE next cycle, uart_tx stays 1, outputs unchanged, no done.
REQ-039 reset low during the third frame byte -> uart_tx=1 same cycle, all outputs 0, FSM IDLE.
REQ-040 start pulsed during SEND, and a beat presented in LATCH -> frame and totals unchanged.
